// File: rtl/rd_empty_gen.sv
// Read-domain empty/occupancy generator for an async FIFO. It synchronizes the Gray
// write pointer into rd_clk and registers empty, almost_empty, rd_count and the Gray read pointer.
module rd_empty_gen #(
    parameter int DEPTH           = 16,
    parameter int ADDR_WIDTH      = 4,
    parameter int SYNC_STAGES     = 2,
    parameter int ALMOST_EMPTY_TH = 2
) (
    input  logic                  rd_clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH:0]   wr_ptr_gray,
    input  logic [ADDR_WIDTH:0]   rd_ptr_ext,
    input  logic                  rd_inc,
    output logic                  empty,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   rd_count,
    output logic [ADDR_WIDTH:0]   rd_ptr_gray
);

    localparam int PW     = ADDR_WIDTH + 1;
    localparam int NSTG   = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
    localparam int TH_EFF = (ALMOST_EMPTY_TH > DEPTH) ? DEPTH : ALMOST_EMPTY_TH;

    logic [PW-1:0] sync_q [NSTG];
    logic [PW-1:0] wq_gray;
    logic [PW-1:0] wq_bin;
    logic [PW-1:0] rd_ptr_next;
    logic [PW-1:0] rd_gray_d;
    logic [PW-1:0] rd_gray_q;
    logic [PW-1:0] rd_count_d;
    logic [PW-1:0] rd_count_q;
    logic          empty_d;
    logic          empty_q;
    logic          almost_empty_d;
    logic          almost_empty_q;
    logic          eff_inc;

    assign wq_gray = sync_q[NSTG-1];

    // Each binary bit is the XOR of all Gray bits at and above it.
    genvar gi;
    generate
        for (gi = 0; gi < PW; gi++) begin : g_gray2bin
            assign wq_bin[gi] = ^wq_gray[PW-1:gi];
        end
    endgenerate

    // Popping while already empty is dropped so the pointer can never pass the writer.
    assign eff_inc        = rd_inc & ~empty_q;
    assign rd_ptr_next    = rd_ptr_ext + {{(PW-1){1'b0}}, eff_inc};
    assign rd_gray_d      = rd_ptr_next ^ (rd_ptr_next >> 1);
    assign empty_d        = (rd_gray_d == wq_gray);
    assign rd_count_d     = wq_bin - rd_ptr_next;
    assign almost_empty_d = (rd_count_d <= PW'(TH_EFF));

    // Pure flop chain: nothing combinational may sit in front of the first stage.
    always_ff @(posedge rd_clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NSTG; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= wr_ptr_gray;
            for (int i = 1; i < NSTG; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    always_ff @(posedge rd_clk) begin
        if (!rst_n) begin
            rd_gray_q      <= '0;
            empty_q        <= 1'b1;
            almost_empty_q <= 1'b1;
            rd_count_q     <= '0;
        end else begin
            rd_gray_q      <= rd_gray_d;
            empty_q        <= empty_d;
            almost_empty_q <= almost_empty_d;
            rd_count_q     <= rd_count_d;
        end
    end

    assign empty        = empty_q;
    assign almost_empty = almost_empty_q;
    assign rd_count     = rd_count_q;
    assign rd_ptr_gray  = rd_gray_q;

endmodule

// File: tb/tb_rd_empty_gen.sv
// Self-checking bench for rd_empty_gen: directed scenarios plus randomized traffic,
// all checked against a pointer-arithmetic occupancy model.
module tb_rd_empty_gen;

    localparam int AW   = 4;
    localparam int PW   = AW + 1;
    localparam int SYNC = 2;
    localparam int TH   = 2;

    logic          rd_clk = 1'b0;
    logic          rst_n;
    logic [PW-1:0] wr_ptr_gray;
    logic [PW-1:0] rd_ptr_ext;
    logic          rd_inc;
    logic          empty;
    logic          almost_empty;
    logic [PW-1:0] rd_count;
    logic [PW-1:0] rd_ptr_gray;

    int pass_cnt  = 0;
    int total_cnt = 0;

    // Reference model state: write-pointer history as seen by the read side, plus expected outputs.
    logic [PW-1:0] hist[$];
    logic          m_empty;
    logic          m_ae;
    logic [PW-1:0] m_count;
    logic [PW-1:0] m_gray;

    wire  [11:0] obs = {empty, almost_empty, rd_count, rd_ptr_gray};
    logic [11:0] expv;

    rd_empty_gen #(
        .DEPTH(16), .ADDR_WIDTH(AW), .SYNC_STAGES(SYNC), .ALMOST_EMPTY_TH(TH)
    ) dut (
        .rd_clk(rd_clk), .rst_n(rst_n), .wr_ptr_gray(wr_ptr_gray), .rd_ptr_ext(rd_ptr_ext),
        .rd_inc(rd_inc), .empty(empty), .almost_empty(almost_empty), .rd_count(rd_count),
        .rd_ptr_gray(rd_ptr_gray)
    );

    always #5 rd_clk = ~rd_clk;

    function automatic int gray2int(input logic [PW-1:0] g);
        int b = 0;
        int bit_v = 0;
        for (int i = PW - 1; i >= 0; i--) begin
            bit_v = bit_v ^ int'(g[i]);
            b = b * 2 + bit_v;
        end
        return b;
    endfunction

    // Drive one cycle, advance the model by the occupancy rules, sample 1 time unit after the edge.
    task automatic tick(input logic rst, input logic [PW-1:0] wg, input logic [PW-1:0] rp, input logic inc);
        int wb, nxt, cnt;
        rst_n = rst; wr_ptr_gray = wg; rd_ptr_ext = rp; rd_inc = inc;
        @(posedge rd_clk);
        if (!rst) begin
            hist = {};
            for (int i = 0; i < SYNC; i++) hist.push_back('0);
            m_empty = 1'b1; m_ae = 1'b1; m_count = '0; m_gray = '0;
        end else begin
            wb  = gray2int(hist[0]);
            nxt = (int'(rp) + ((inc && !m_empty) ? 1 : 0)) % 32;
            cnt = (wb - nxt + 32) % 32;
            m_empty = (cnt == 0);
            m_ae    = (cnt <= TH);
            m_count = PW'(cnt);
            m_gray  = PW'(nxt ^ (nxt >> 1));
            hist.push_back(wg);
            void'(hist.pop_front());
        end
        expv = {m_empty, m_ae, m_count, m_gray};
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) tick(1'b0, 5'b00011, 5'd0, 1'b0);
        total_cnt++;
        if (obs !== 12'b1_1_00000_00000) $display("FAIL reset_state obs=%b required=%b", obs, 12'b1_1_00000_00000);
        else pass_cnt++;
        for (int e = 1; e <= 3; e++) begin
            tick(1'b1, 5'b00011, 5'd0, 1'b0);
            total_cnt++;
            if (obs !== expv || rd_count !== ((e < 3) ? 5'd0 : 5'd2) || almost_empty !== 1'b1)
                $display("FAIL reset_release edge=%0d obs=%b required=%b", e, obs, expv);
            else pass_cnt++;
        end
    endtask

    task automatic test_sync_latency();
        tick(1'b0, 5'd0, 5'd0, 1'b0);
        for (int i = 0; i < 3; i++) tick(1'b1, 5'd0, 5'd0, 1'b0);
        for (int e = 1; e <= 3; e++) begin
            tick(1'b1, 5'b00001, 5'd0, 1'b0);
            total_cnt++;
            if (obs !== expv || empty !== (e < 3) || rd_count !== ((e < 3) ? 5'd0 : 5'd1) || almost_empty !== 1'b1)
                $display("FAIL sync_latency edge=%0d obs=%b required=%b", e, obs, expv);
            else pass_cnt++;
        end
    endtask

    task automatic test_full();
        tick(1'b0, 5'd0, 5'd0, 1'b0);
        for (int i = 0; i < 3; i++) tick(1'b1, 5'b11000, 5'd0, 1'b0);
        total_cnt++;
        if (obs !== expv || rd_count !== 5'd16 || empty !== 1'b0 || almost_empty !== 1'b0)
            $display("FAIL full_count obs=%b required=%b", obs, expv);
        else pass_cnt++;
    endtask

    task automatic test_pop_last();
        tick(1'b0, 5'd0, 5'd0, 1'b0);
        for (int i = 0; i < 3; i++) tick(1'b1, 5'b00001, 5'd0, 1'b0);
        total_cnt++;
        if (obs !== expv || rd_count !== 5'd1 || empty !== 1'b0)
            $display("FAIL pop_last_pre obs=%b required=%b", obs, expv);
        else pass_cnt++;
        tick(1'b1, 5'b00001, 5'd0, 1'b1);
        total_cnt++;
        if (obs !== expv || obs !== 12'b1_1_00000_00001)
            $display("FAIL pop_last obs=%b required=%b", obs, 12'b1_1_00000_00001);
        else pass_cnt++;
    endtask

    task automatic test_wrap();
        tick(1'b0, 5'd0, 5'd0, 1'b0);
        tick(1'b1, 5'd0, 5'd31, 1'b0);
        total_cnt++;
        if (obs !== expv || rd_count !== 5'd1 || empty !== 1'b0 || rd_ptr_gray !== 5'b10000)
            $display("FAIL wrap_count obs=%b required=%b", obs, expv);
        else pass_cnt++;
        tick(1'b1, 5'd0, 5'd31, 1'b1);
        total_cnt++;
        if (obs !== expv || empty !== 1'b1 || rd_ptr_gray !== 5'd0 || rd_count !== 5'd0)
            $display("FAIL wrap_pop obs=%b required=%b", obs, expv);
        else pass_cnt++;
    endtask

    task automatic test_pop_empty();
        tick(1'b0, 5'd0, 5'd0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            tick(1'b1, 5'd0, 5'd0, 1'b1);
            total_cnt++;
            if (obs !== expv || obs !== 12'b1_1_00000_00000)
                $display("FAIL pop_empty cyc=%0d obs=%b required=%b", i, obs, 12'b1_1_00000_00000);
            else pass_cnt++;
        end
    endtask

    task automatic test_random();
        logic [PW-1:0] wb = '0;
        logic [PW-1:0] rp = '0;
        logic          inc;
        logic          was_empty;
        tick(1'b0, 5'd0, 5'd0, 1'b0);
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 59) == 0) begin
                wb = '0; rp = '0;
                tick(1'b0, 5'd0, 5'd0, 1'b0);
            end else begin
                if ($urandom_range(0, 1) == 1 && PW'(wb - rp) < 5'd16) wb = wb + 1'b1;
                inc = ($urandom_range(0, 2) != 0);
                was_empty = m_empty;
                tick(1'b1, wb ^ (wb >> 1), rp, inc);
                if (inc && !was_empty) rp = rp + 1'b1;
            end
            total_cnt++;
            if (obs !== expv) $display("FAIL random cyc=%0d obs=%b required=%b", c, obs, expv);
            else pass_cnt++;
        end
    endtask

    initial begin
        rst_n = 1'b0; wr_ptr_gray = '0; rd_ptr_ext = '0; rd_inc = 1'b0;
        @(negedge rd_clk);
        test_reset();
        test_sync_latency();
        test_full();
        test_pop_last();
        test_wrap();
        test_pop_empty();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/rd_empty_gen.md
RD_EMPTY_GEN -- requirements
Module: rd_empty_gen

Interface
REQ-001 Parameter DEPTH, default 16: FIFO entries; SHALL equal 2**ADDR_WIDTH.
REQ-002 Parameter ADDR_WIDTH, default 4: RAM address width; pointers SHALL be ADDR_WIDTH+1 bits wide.
REQ-003 Parameter SYNC_STAGES, default 2, minimum 2: flop count in the write-pointer synchronizer.
REQ-004 Parameter ALMOST_EMPTY_TH, default 2, range 0..DEPTH: almost_empty threshold.
REQ-005 rd_clk  input  1  read-domain clock; all state SHALL be clocked on its rising edge.
REQ-006 rst_n  input  1  reset: synchronous, active-low, sampled on rd_clk.
REQ-007 wr_ptr_gray  input  ADDR_WIDTH+1  registered Gray write pointer from the wr_clk domain; asynchronous to rd_clk.
REQ-008 rd_ptr_ext  input  ADDR_WIDTH+1  current binary read pointer from the read controller.
REQ-009 rd_inc  input  1  read-pointer advance this cycle (the RAM read enable).
REQ-010 empty  output  1  registered empty flag.
REQ-011 almost_empty  output  1  registered, high when occupancy <= ALMOST_EMPTY_TH.
REQ-012 rd_count  output  ADDR_WIDTH+1  registered read-domain occupancy, 0..DEPTH.
REQ-013 rd_ptr_gray  output  ADDR_WIDTH+1  registered Gray read pointer for synchronization into wr_clk.

Function
REQ-014 wr_ptr_gray SHALL pass through a chain of SYNC_STAGES flops, with no logic between stages or ahead of the first stage; the last stage is wq_gray.
REQ-015 wq_bin SHALL be the combinational Gray-to-binary conversion of wq_gray.
REQ-016 eff_inc SHALL equal rd_inc AND NOT empty; rd_inc while empty=1 SHALL be ignored.
REQ-017 rd_ptr_next SHALL equal rd_ptr_ext + eff_inc, modulo 2**(ADDR_WIDTH+1).
REQ-018 Each edge: rd_ptr_gray <= rd_ptr_next XOR (rd_ptr_next >> 1).
REQ-019 Each edge: empty <= (Gray(rd_ptr_next) == wq_gray), compared on the full ADDR_WIDTH+1 bits.
REQ-020 Each edge: rd_count <= (wq_bin - rd_ptr_next) modulo 2**(ADDR_WIDTH+1).
REQ-021 Each edge: almost_empty <= (that same next rd_count value <= ALMOST_EMPTY_TH).
REQ-022 A pop of the last entry SHALL raise empty on the same edge that advances the read pointer, with zero lag.
REQ-023 A write-pointer change SHALL be reflected in empty and rd_count on the (SYNC_STAGES+1)th rd_clk edge after it reaches the input.
REQ-024 The flags are pessimistic: empty may stay high after data arrives but SHALL never be low while the FIFO is empty.
REQ-025 Wrap-around: both pointers wrap at 2**(ADDR_WIDTH+1) with no special case.
REQ-026 Full condition (MSBs differ, lower bits equal) SHALL produce rd_count=DEPTH, empty=0.
REQ-027 A pop and a write-pointer update in the same cycle SHALL both apply, with no priority between them.
REQ-028 The wr_ptr_gray driver SHALL change at most one bit per wr_clk edge; the block performs no multi-bit checking.

Reset
REQ-029 While rst_n=0 on an edge: all synchronizer stages <= 0, rd_ptr_gray <= 0, empty <= 1, almost_empty <= 1, rd_count <= 0.
REQ-030 Reset mid-operation SHALL discard synchronizer contents immediately; the write domain SHALL be reset concurrently.
REQ-031 After reset release, the first update SHALL occur on the first edge with rst_n=1.

Verification
REQ-032 Scenario: reset with wr_ptr_gray=5'b00011 -> after reset empty=1, almost_empty=1, rd_count=0, rd_ptr_gray=0.
REQ-033 Scenario: rd_ptr_ext=0, wr_ptr_gray steps 0->5'b00001, rd_inc=0 -> empty falls and rd_count=1 exactly on the 3rd edge (SYNC_STAGES=2); almost_empty stays 1.
REQ-034 Scenario: wr_ptr_gray=5'b11000 (binary 16), rd_ptr_ext=0 -> after 3 edges rd_count=16, empty=0, almost_empty=0.
REQ-035 Scenario: count 1 (wq_bin=1, rd_ptr_ext=0), rd_inc=1 -> next edge empty=1, rd_count=0, rd_ptr_gray=5'b00001.
REQ-036 Scenario: wrap, rd_ptr_ext=31, wq_bin=0 -> rd_count=1, empty=0; pop -> empty=1, rd_ptr_gray=0.
REQ-037 Scenario: empty=1, rd_inc=1 for 4 cycles -> rd_ptr_gray, rd_count and empty unchanged.
